// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared barrel shifter.
// Left shifts reuse the right shifter by reversing the operand before and after.
module shift_arbiter #(
    parameter int N = 8,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_data,
    input  logic [S-1:0] req0_amt,
    input  logic         req0_left,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_data,
    input  logic [S-1:0] req1_amt,
    input  logic         req1_left,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_src
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never waits on a clock, and out_* change only on edges.

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_data_q,  out_data_d;
    logic         out_src_q,   out_src_d;
    logic         last_grant_q, last_grant_d;

    logic         can_accept;
    logic         grant;
    logic         accept;
    logic [N-1:0] sel_data;
    logic [S-1:0] sel_amt;
    logic         sel_left;
    logic [N-1:0] a_hat;
    logic [N-1:0] shifted;
    logic [N-1:0] result;

    function automatic logic [N-1:0] reverse_bits(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // The slot is free when empty or when its current result leaves this cycle.
    assign can_accept = !out_valid_q || out_ready;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = !last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = can_accept && req0_valid && (grant == 1'b0);
    assign req1_ready = can_accept && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;

    assign sel_data = grant ? req1_data : req0_data;
    assign sel_amt  = grant ? req1_amt  : req0_amt;
    assign sel_left = grant ? req1_left : req0_left;

    assign a_hat   = sel_left ? reverse_bits(sel_data) : sel_data;
    assign shifted = a_hat >> sel_amt;
    assign result  = sel_left ? reverse_bits(shifted) : shifted;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = result;
            out_src_d    = grant;
            last_grant_d = grant;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: cycle-by-cycle vector table, reset and
// backpressure sequences, and an exhaustive datapath sweep against a shift model.
module tb_shift_arbiter;

    localparam int N = 8;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_left;
    logic [N-1:0] req0_data;
    logic [S-1:0] req0_amt;
    logic         req1_valid, req1_ready, req1_left;
    logic [N-1:0] req1_data;
    logic [S-1:0] req1_amt;
    logic         out_valid, out_ready, out_src;
    logic [N-1:0] out_data;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    shift_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_left  (req0_left),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_left  (req1_left),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic         v0;
        logic [N-1:0] d0;
        logic [S-1:0] a0;
        logic         l0;
        logic         v1;
        logic [N-1:0] d1;
        logic [S-1:0] a1;
        logic         l1;
        logic         ordy;
        logic         e_r0;
        logic         e_r1;
        logic         e_ov;
        logic [N-1:0] e_data;
        logic         e_src;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive0(input logic v, input logic [N-1:0] d, input logic [S-1:0] a, input logic l);
        req0_valid = v; req0_data = d; req0_amt = a; req0_left = l;
    endtask

    task automatic drive1(input logic v, input logic [N-1:0] d, input logic [S-1:0] a, input logic l);
        req1_valid = v; req1_data = d; req1_amt = a; req1_left = l;
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive0(1'b0, '0, '0, 1'b0);
        drive1(1'b0, '0, '0, 1'b0);

        //             v0    d0     a0    l0    v1    d1     a1    l1    rdy   r0    r1    ov    data   src
        vecs[0]  = '{1'b1, 8'h68, 3'd2, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h2D, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1};
        vecs[2]  = '{1'b1, 8'hB7, 3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB7, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'hB7, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB7, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB7, 1'b1};
        vecs[5]  = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[6]  = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1};
        vecs[7]  = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[8]  = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1};
        vecs[9]  = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1};
        vecs[10] = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1};
        vecs[11] = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1};
        vecs[12] = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[13] = '{1'b1, 8'h81, 3'd1, 1'b1, 1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1};
        vecs[14] = '{1'b1, 8'h01, 3'd7, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1};
        vecs[16] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1};
        vecs[18] = '{1'b1, 8'hF0, 3'd4, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0};

        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data",  32'(out_data),  32'd0);
        check("reset out_src",   32'(out_src),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // vector table: one cycle per entry, readies before the edge, outputs after
        for (int i = 0; i < NV; i++) begin
            drive0(vecs[i].v0, vecs[i].d0, vecs[i].a0, vecs[i].l0);
            drive1(vecs[i].v1, vecs[i].d1, vecs[i].a1, vecs[i].l1);
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0));
            check($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].e_data));
            check($sformatf("v%0d out_src", i),   32'(out_src),   32'(vecs[i].e_src));
        end

        // asynchronous reset while a result is stalled
        out_ready = 1'b0;
        drive0(1'b1, 8'h81, 3'd1, 1'b1);
        drive1(1'b1, 8'h81, 3'd1, 1'b0);
        #2;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post-reset req0_ready", 32'(req0_ready), 32'd1);
        check("post-reset req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post-reset first src",  32'(out_src),  32'd0);
        check("post-reset first data", 32'(out_data), 32'h02);
        @(posedge clk);
        #1;
        check("post-reset second src",  32'(out_src),  32'd1);
        check("post-reset second data", 32'(out_data), 32'h40);

        // exhaustive datapath sweep through requester 0
        drive1(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int d = 0; d < 256; d++) begin
            for (int a = 0; a < 8; a++) begin
                for (int l = 0; l < 2; l++) begin
                    logic [N-1:0] dv;
                    logic [N-1:0] ev;
                    dv = 8'(d);
                    ev = (l == 1) ? (dv << a) : (dv >> a);
                    drive0(1'b1, dv, 3'(a), 1'(l));
                    exp_q.push_back(ev);
                    @(posedge clk);
                    #1;
                    check("sweep out_valid", 32'(out_valid), 32'd1);
                    check($sformatf("sweep d=%0h a=%0d l=%0d", d, a, l),
                          32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
        drive0(1'b0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
